axi_slave_mem: RTL and testbench
================================

Name: axi_slave_mem

Overview:
- AXI4 memory-mapped responder: the far end of the team's AXI master (`top`).
- Accepts write bursts on AW/W, returns a B response, serves read bursts on AR/R from an internal word-addressed memory.
- Write and read channels run as independent FSMs.
- Used as the DUT-side target so master bursts (len up to 16, 8-bit data) complete end to end.

Parameters:
- ADDR_W, 8, byte-address width
- DATA_W, 8, data bus width in bits (multiple of 8)
- ID_W, 4, transaction ID width
- MEM_DEPTH, 256, number of DATA_W words

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- awid  in  ID_W  write ID
- awaddr  in  ADDR_W  write start byte address
- awlen  in  8  beats-1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- awvalid  in  1 / awready  out  1  AW handshake
- wdata  in  DATA_W / wstrb  in  DATA_W/8 / wlast  in  1  write beat
- wvalid  in  1 / wready  out  1  W handshake
- bid  out  ID_W / bresp  out  2  write response
- bvalid  out  1 / bready  in  1  B handshake
- arid, araddr, arlen, arsize, arburst  in  as AW counterparts
- arvalid  in  1 / arready  out  1  AR handshake
- rid  out  ID_W / rdata  out  DATA_W / rresp  out  2 / rlast  out  1  read beat
- rvalid  out  1 / rready  in  1  R handshake

Behaviour:
- Reset: awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bresp, rresp, bid, rid, rdata=0. FSMs go to IDLE. Memory is not cleared unless AXI_SLV_MEM_INIT_EN is defined.
- Reset mid-burst aborts the burst immediately. No B or R beat is issued for it.
- Word index = (addr >> log2(DATA_W/8)) mod MEM_DEPTH. Upper bits alias.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On awvalid&&awready, latch id, addr, len, size, burst; clear beat count; go to W_DATA next cycle.
  - W_DATA: wready=1. Each wvalid&&wready writes byte lanes where wstrb=1 at the clock edge.
  - INCR: address += DATA_W/8 per beat. FIXED: address held.
  - Count reaching len ends the burst -> W_RESP; the beat counter is authoritative.
  - wlast at the wrong beat, or missing on the last beat, flags SLVERR.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then W_IDLE; awready returns the next cycle.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On handshake, latch fields. rvalid=1 the next cycle.
  - R_DATA: rdata = mem[current index], rid=latched id, rlast=(count==len).
  - On rvalid&&rready, advance address and count. After the beat with rlast, go to R_IDLE.
  - With rvalid&&!rready, rdata, rresp and rlast hold stable.
- Error: awburst/arburst=WRAP(10) or 11, or size != log2(DATA_W/8), gives SLVERR(10).
  - Errored writes still consume all len+1 beats but do not write memory.
  - Errored reads return len+1 beats of rdata=0 with rresp=SLVERR on every beat.
- Otherwise responses are OKAY(00).
- Max throughput: one W beat per cycle and one R beat per cycle, concurrently.
- Same-cycle read and write to one index: the read returns the old value; the write lands at the edge.
- No outstanding-transaction queuing: one write and one read in flight at a time.

Optional Feature:
- AXI_SLV_MEM_INIT_EN defined: areset assertion clears every memory word to 0; reads after reset return 0.
- Not defined: memory has no reset; contents persist across areset, and post-reset reads of written locations return prior data.

Decomposition:
- Package axi_slave_pkg holds:
  - burst_t enum: FIXED, INCR, WRAP
  - resp_t enum: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11
  - wr_state_t and rd_state_t enums
  - BYTES_PER_BEAT function
- Sub-module axi_slave_mem_array: MEM_DEPTH x DATA_W, one strobed synchronous write port, one asynchronous read port.

Test Plan:
- INCR write awaddr=0x10, awlen=3, wdata 0xA1..0xA4, wstrb=1 -> bvalid one cycle after the 4th beat, bresp=00, bid echoes awid=5. Read araddr=0x10, arlen=3 -> rdata A1,A2,A3,A4, rlast only on beat 4.
- FIXED write awaddr=0x20, awlen=2, data 11/22/33 -> read len 0 of 0x20 returns 0x33.
- rready toggled 1,0,0,1 during a 16-beat read -> rdata/rlast stable while stalled; 16 beats delivered, none lost.
- awburst=WRAP, awlen=1 -> both W beats accepted, bresp=10, memory unchanged on readback.
- wlast asserted on beat 1 of awlen=2 -> 3 beats still consumed, bresp=10.
- Write 0x5A to 0x30, pulse areset for 2 cycles, then read 0x30 -> 0x5A without the macro, 0x00 with AXI_SLV_MEM_INIT_EN. Also assert areset mid read burst -> rvalid=0 the next cycle, arready=1.

Source files
------------

// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared burst/response/state types and beat-size helper for axi_slave_mem.
package axi_slave_pkg;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic int BYTES_PER_BEAT(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/axi_slave_mem_array.sv
// axi_slave_mem_array: word memory, strobed sync write, async read.
// AXI_SLV_MEM_INIT_EN clears all words on rst; otherwise contents survive reset.
module axi_slave_mem_array
    import axi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = BYTES_PER_BEAT(DATA_W);
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    assign rdata = mem_q[raddr];
`ifdef AXI_SLV_MEM_INIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < NB; b++) if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
`else
    logic unused_rst;
    assign unused_rst = rst;
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NB; b++) if (wstrb[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
`endif
endmodule

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 burst responder over an internal word memory, independent write/read FSMs.
// Define AXI_SLV_MEM_INIT_EN to clear the memory on areset.
module axi_slave_mem
    import axi_slave_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
)(
    input  logic                aclk,
    input  logic                areset,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);
    localparam int BPB   = BYTES_PER_BEAT(DATA_W);
    localparam int SHIFT = $clog2(BPB);
    localparam int IDX_W = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((32'(a) >> SHIFT) % MEM_DEPTH);
    endfunction

    function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
        return burst[1] || size != 3'(SHIFT);
    endfunction

    wr_state_t         wst_q, wst_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    resp_t             bresp_q, bresp_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic              wfixed_q, wfixed_d, werr_q, werr_d, wlerr_q, wlerr_d;

    rd_state_t         rdst_q, rdst_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    resp_t             rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, mem_rdata;
    logic [ADDR_W-1:0] raddr_q, raddr_d, rnext;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic              rfixed_q, rfixed_d, rerr_q, rerr_d;

    logic wbeat, wend, rbeat;

    assign wbeat = wready_q && wvalid;
    assign wend  = wcnt_q == wlen_q;
    assign rbeat = rvalid_q && rready;
    assign rnext = rfixed_q ? raddr_q : raddr_q + ADDR_W'(BPB);

    axi_slave_mem_array #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_mem (
        .clk   (aclk),
        .rst   (areset),
        .we    (wbeat && !werr_q),
        .waddr (word_idx(waddr_q)),
        .wdata (wdata),
        .wstrb (wstrb),
        .raddr (word_idx(rdst_q == R_IDLE ? araddr : rnext)),
        .rdata (mem_rdata)
    );

    always_comb begin
        wst_d = wst_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
        bid_d = bid_q; bresp_d = bresp_q; waddr_d = waddr_q; wlen_d = wlen_q; wcnt_d = wcnt_q;
        wfixed_d = wfixed_q; werr_d = werr_q; wlerr_d = wlerr_q;
        if (wst_q == W_IDLE && awvalid && awready_q) begin
            wst_d = W_DATA; awready_d = 1'b0; wready_d = 1'b1;
            bid_d = awid; waddr_d = awaddr; wlen_d = awlen; wcnt_d = '0;
            wfixed_d = awburst == FIXED; werr_d = bad_req(awburst, awsize); wlerr_d = 1'b0;
        end else if (wst_q == W_DATA && wbeat) begin
            waddr_d = wfixed_q ? waddr_q : waddr_q + ADDR_W'(BPB);
            wcnt_d  = wcnt_q + 8'd1;
            wlerr_d = wlerr_q || (wlast != wend);
            if (wend) begin
                wst_d = W_RESP; wready_d = 1'b0; bvalid_d = 1'b1;
                bresp_d = (werr_q || wlerr_d) ? SLVERR : OKAY;
            end
        end else if (wst_q == W_RESP && bready) begin
            wst_d = W_IDLE; bvalid_d = 1'b0; awready_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wst_q <= W_IDLE; awready_q <= 1'b1; wready_q <= 1'b0; bvalid_q <= 1'b0;
            bid_q <= '0; bresp_q <= OKAY; waddr_q <= '0; wlen_q <= '0; wcnt_q <= '0;
            wfixed_q <= 1'b0; werr_q <= 1'b0; wlerr_q <= 1'b0;
        end else begin
            wst_q <= wst_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
            bid_q <= bid_d; bresp_q <= bresp_d; waddr_q <= waddr_d; wlen_q <= wlen_d; wcnt_q <= wcnt_d;
            wfixed_q <= wfixed_d; werr_q <= werr_d; wlerr_q <= wlerr_d;
        end
    end

    // Read beat is registered one ahead so a stalled beat cannot change under a concurrent write.
    always_comb begin
        rdst_d = rdst_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
        rid_d = rid_q; rresp_d = rresp_q; rdata_d = rdata_q; raddr_d = raddr_q;
        rlen_d = rlen_q; rcnt_d = rcnt_q; rfixed_d = rfixed_q; rerr_d = rerr_q;
        if (rdst_q == R_IDLE && arvalid && arready_q) begin
            rdst_d = R_DATA; arready_d = 1'b0; rvalid_d = 1'b1;
            rid_d = arid; raddr_d = araddr; rlen_d = arlen; rcnt_d = '0;
            rfixed_d = arburst == FIXED; rerr_d = bad_req(arburst, arsize);
            rlast_d = arlen == 8'd0;
            rresp_d = rerr_d ? SLVERR : OKAY;
            rdata_d = rerr_d ? '0 : mem_rdata;
        end else if (rbeat && rlast_q) begin
            rdst_d = R_IDLE; rvalid_d = 1'b0; rlast_d = 1'b0; arready_d = 1'b1;
        end else if (rbeat) begin
            raddr_d = rnext; rcnt_d = rcnt_q + 8'd1;
            rlast_d = rcnt_d == rlen_q;
            rdata_d = rerr_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdst_q <= R_IDLE; arready_q <= 1'b1; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rid_q <= '0; rresp_q <= OKAY; rdata_q <= '0; raddr_q <= '0;
            rlen_q <= '0; rcnt_q <= '0; rfixed_q <= 1'b0; rerr_q <= 1'b0;
        end else begin
            rdst_q <= rdst_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
            rid_q <= rid_d; rresp_q <= rresp_d; rdata_q <= rdata_d; raddr_q <= raddr_d;
            rlen_q <= rlen_d; rcnt_q <= rcnt_d; rfixed_q <= rfixed_d; rerr_q <= rerr_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed bursts against axi_slave_mem with hand-computed expectations.
module tb_axi_slave_mem;
    logic       aclk, areset;
    logic [3:0] awid, arid, bid, rid;
    logic [7:0] awaddr, awlen, araddr, arlen, wdata, rdata;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic       awvalid, awready, wstrb, wlast, wvalid, wready, bvalid, bready;
    logic       arvalid, arready, rlast, rvalid, rready;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] wd [16];
    logic [7:0] rdat [16];
    logic       rlst [16];
    logic [1:0] rrsp [16];
    int         nb;
    logic [3:0] rid_s;
    logic [1:0] resp;
    logic [3:0] bid_o;

    axi_slave_mem dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int lastpos,
                            output logic [1:0] resp_o, output logic [3:0] id_o);
        int n;
        @(negedge aclk);
        awid = id; awaddr = addr; awlen = len; awsize = 3'd0; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        chk("awready", awready, 1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata = wd[b]; wstrb = 1'b1; wlast = (b == lastpos); wvalid = 1'b1;
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            chk("wready", wready, 1);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk("bvalid_after_last", bvalid, 1);
        resp_o = bresp; id_o = bid;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("awready_back", awready, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [7:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [3:0] pat);
        int n;
        logic stalled;
        logic [7:0] pd;
        logic pl;
        nb = 0; stalled = 1'b0; pd = '0; pl = 1'b0;
        @(negedge aclk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        chk("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
        n = 0;
        while (nb <= int'(len) && n < 200) begin
            rready = pat[n % 4];
            if (stalled) begin
                chk("rdata_stable", rdata, pd);
                chk("rlast_stable", rlast, pl);
            end
            stalled = rvalid && !rready; pd = rdata; pl = rlast;
            if (rvalid && rready) begin
                rdat[nb] = rdata; rlst[nb] = rlast; rrsp[nb] = rresp; rid_s = rid; nb++;
            end
            @(negedge aclk);
            n++;
        end
        rready = 1'b0;
        chk("read_beats", nb, len + 1);
        chk("rvalid_done", rvalid, 0);
        chk("arready_idle", arready, 1);
    endtask

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rdata", rdata, 0);

        // INCR write then read back
        for (int i = 0; i < 4; i++) wd[i] = 8'hA1 + 8'(i);
        do_write(4'd5, 8'h10, 8'd3, 2'b01, 3, resp, bid_o);
        chk("incr_bresp", resp, 2'b00);
        chk("incr_bid", bid_o, 4'd5);
        do_read(4'd3, 8'h10, 8'd3, 2'b01, 3'd0, 4'b1111);
        chk("incr_rid", rid_s, 4'd3);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rdat[i], 8'hA1 + 8'(i));
            chk("incr_rlast", rlst[i], i == 3);
            chk("incr_rresp", rrsp[i], 2'b00);
        end

        // FIXED write: last beat wins
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
        do_write(4'd1, 8'h20, 8'd2, 2'b00, 2, resp, bid_o);
        chk("fixed_bresp", resp, 2'b00);
        do_read(4'd2, 8'h20, 8'd0, 2'b01, 3'd0, 4'b1111);
        chk("fixed_rdata", rdat[0], 8'h33);
        chk("fixed_rlast", rlst[0], 1);

        // 16-beat read with rready pattern 1,0,0,1
        for (int i = 0; i < 16; i++) wd[i] = 8'hC0 + 8'(i);
        do_write(4'd7, 8'h40, 8'd15, 2'b01, 15, resp, bid_o);
        chk("long_bresp", resp, 2'b00);
        do_read(4'd9, 8'h40, 8'd15, 2'b01, 3'd0, 4'b1001);
        for (int i = 0; i < 16; i++) begin
            chk("long_rdata", rdat[i], 8'hC0 + 8'(i));
            chk("long_rlast", rlst[i], i == 15);
        end

        // WRAP write: consumed, SLVERR, memory untouched
        wd[0] = 8'hEE; wd[1] = 8'hFF;
        do_write(4'd4, 8'h10, 8'd1, 2'b10, 1, resp, bid_o);
        chk("wrap_bresp", resp, 2'b10);
        chk("wrap_bid", bid_o, 4'd4);
        do_read(4'd3, 8'h10, 8'd1, 2'b01, 3'd0, 4'b1111);
        chk("wrap_keep0", rdat[0], 8'hA1);
        chk("wrap_keep1", rdat[1], 8'hA2);

        // wlast early on beat 1 of a 3-beat burst
        wd[0] = 8'h01; wd[1] = 8'h02; wd[2] = 8'h03;
        do_write(4'd6, 8'h50, 8'd2, 2'b01, 1, resp, bid_o);
        chk("wlast_bresp", resp, 2'b10);

        // Bad arsize: zero data, SLVERR on every beat
        do_read(4'd8, 8'h10, 8'd1, 2'b01, 3'd1, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            chk("size_rdata", rdat[i], 8'h00);
            chk("size_rresp", rrsp[i], 2'b10);
        end
        chk("size_rlast", rlst[1], 1);

        // Memory across reset
        wd[0] = 8'h5A;
        do_write(4'd2, 8'h30, 8'd0, 2'b01, 0, resp, bid_o);
        chk("persist_bresp", resp, 2'b00);
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        chk("rst2_awready", awready, 1);
        chk("rst2_bid", bid, 0);
        do_read(4'd1, 8'h30, 8'd0, 2'b01, 3'd0, 4'b1111);
`ifdef AXI_SLV_MEM_INIT_EN
        chk("persist_rdata", rdat[0], 8'h00);
`else
        chk("persist_rdata", rdat[0], 8'h5A);
`endif

        // Reset in the middle of a read burst
        @(negedge aclk);
        arid = 4'd3; araddr = 8'h40; arlen = 8'd15; arsize = 3'd0; arburst = 2'b01; arvalid = 1'b1;
        rready = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        repeat (2) @(negedge aclk);
        chk("mid_rvalid_before", rvalid, 1);
        areset = 1'b1;
        rready = 1'b0;
        @(negedge aclk);
        chk("mid_rvalid", rvalid, 0);
        chk("mid_arready", arready, 1);
        chk("mid_rlast", rlast, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("mid_rvalid_after", rvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
